pending_bitmap_dispatcher: RTL and testbench



---
 rtl/onehot_priority.sv | 30 +++
 rtl/pending_bitmap_dispatcher.sv | 99 +++++++++
 tb/tb_pending_bitmap_dispatcher.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_priority.sv
// Fixed-priority one-hot picker: grants the lowest (or highest) set request bit.
module onehot_priority #(
   parameter int W_INPUT      = 8,
   parameter int HIGHEST_WINS = 0
) (
   input  logic [W_INPUT-1:0] i_req,
   output logic [W_INPUT-1:0] o_grant
);

   // Scan from the losing end toward the winning end so the last hit is the winner.
   always_comb begin
      o_grant = '0;
      if (HIGHEST_WINS != 0) begin
         for (int i = 0; i < W_INPUT; i++) begin
            if (i_req[i]) begin
               o_grant    = '0;
               o_grant[i] = 1'b1;
            end
         end
      end else begin
         for (int i = W_INPUT - 1; i >= 0; i--) begin
            if (i_req[i]) begin
               o_grant    = '0;
               o_grant[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pending_bitmap_dispatcher.sv
// Sticky pending-event bitmap served one index at a time over a valid/ready port.
module pending_bitmap_dispatcher #(
   parameter int W_INPUT      = 8,
   parameter int HIGHEST_WINS = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [W_INPUT-1:0]           set_in,
   input  logic [W_INPUT-1:0]           clr_in,
   output logic [W_INPUT-1:0]           pending,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [$clog2(W_INPUT)-1:0]   out_idx,
   output logic [W_INPUT-1:0]           out_onehot
);

   localparam int W_INDEX = $clog2(W_INPUT);

   localparam logic IDLE  = 1'b0;
   localparam logic OFFER = 1'b1;

   logic                 r_state;
   logic [W_INPUT-1:0]   r_pending;
   logic                 r_vld;
   logic [W_INPUT-1:0]   r_onehot;
   logic [W_INDEX-1:0]   r_idx;

   logic                 w_hs;
   logic [W_INPUT-1:0]   w_next;
   logic [W_INPUT-1:0]   w_sel_in;
   logic [W_INPUT-1:0]   w_pick;

   // OR together the indices of set bits; with a one-hot input this is the binary index.
   function automatic logic [W_INDEX-1:0] onehot_to_bin(input logic [W_INPUT-1:0] oh);
      logic [W_INDEX-1:0] b;
      b = '0;
      for (int i = 0; i < W_INPUT; i++) begin
         if (oh[i]) b = b | W_INDEX'(i);
      end
      return b;
   endfunction

   assign w_hs   = r_vld & out_rdy;
   // set wins over clr, clr wins over service
   assign w_next = (r_pending & ~clr_in & ~(w_hs ? r_onehot : '0)) | set_in;
   // IDLE picks from the registered bitmap; OFFER re-picks from the post-handshake bitmap.
   assign w_sel_in = (r_state == OFFER) ? w_next : r_pending;

   onehot_priority #(
      .W_INPUT      (W_INPUT),
      .HIGHEST_WINS (HIGHEST_WINS)
   ) u_pick (
      .i_req   (w_sel_in),
      .o_grant (w_pick)
   );

   // Pending bitmap and offer FSM; an offer is only replaced or dropped on a handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_vld     <= 1'b0;
         r_onehot  <= '0;
         r_idx     <= '0;
      end else begin
         r_pending <= w_next;
         case (r_state)
            IDLE: begin
               if (r_pending != '0) begin
                  r_onehot <= w_pick;
                  r_idx    <= onehot_to_bin(w_pick);
                  r_vld    <= 1'b1;
                  r_state  <= OFFER;
               end
            end
            OFFER: begin
               if (w_hs) begin
                  if (w_next != '0) begin
                     r_onehot <= w_pick;
                     r_idx    <= onehot_to_bin(w_pick);
                  end else begin
                     r_onehot <= '0;
                     r_idx    <= '0;
                     r_vld    <= 1'b0;
                     r_state  <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pending    = r_pending;
   assign out_vld    = r_vld;
   assign out_idx    = r_idx;
   assign out_onehot = r_onehot;

endmodule

// File: tb/tb_pending_bitmap_dispatcher.sv
// Bench: table vectors, hand-written corner sequences, and a randomized run
// compared against a bitmap/index reference model.
module tb_pending_bitmap_dispatcher;

   logic       clk;
   logic       rst_n, out_rdy;
   logic [7:0] set_in, clr_in, pending, out_onehot;
   logic       out_vld;
   logic [2:0] out_idx;

   logic       rst_h, rdy_h;
   logic [7:0] set_h, clr_h, pend_h, oh_h;
   logic       vld_h;
   logic [2:0] idx_h;

   int n_vec = 0;
   int n_err = 0;

   pending_bitmap_dispatcher #(.W_INPUT(8), .HIGHEST_WINS(0)) dut (
      .clk(clk), .rst_n(rst_n), .set_in(set_in), .clr_in(clr_in),
      .pending(pending), .out_vld(out_vld), .out_rdy(out_rdy),
      .out_idx(out_idx), .out_onehot(out_onehot)
   );

   pending_bitmap_dispatcher #(.W_INPUT(8), .HIGHEST_WINS(1)) dut_hi (
      .clk(clk), .rst_n(rst_h), .set_in(set_h), .clr_in(clr_h),
      .pending(pend_h), .out_vld(vld_h), .out_rdy(rdy_h),
      .out_idx(idx_h), .out_onehot(oh_h)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst_n;
      logic [7:0] set;
      logic [7:0] clr;
      logic       rdy;
      logic [7:0] e_pend;
      logic       e_vld;
      logic [2:0] e_idx;
      logic [7:0] e_oh;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [7:0] s, logic [7:0] c, logic y,
                               logic [7:0] p, logic v, logic [2:0] ix, logic [7:0] oh);
      vec_t t;
      t.rst_n = r; t.set = s; t.clr = c; t.rdy = y;
      t.e_pend = p; t.e_vld = v; t.e_idx = ix; t.e_oh = oh;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [7:0] s, input logic [7:0] c, input logic y);
      rst_n = r; set_in = s; clr_in = c; out_rdy = y;
      step();
   endtask

   // reference model: bitmap plus currently offered index (-1 = no offer)
   logic [7:0] m_pend;
   int         m_off;

   function automatic int pick(input logic [7:0] v, input bit hi);
      int r;
      r = -1;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            if (hi) r = i;
            else if (r < 0) r = i;
         end
      end
      return r;
   endfunction

   task automatic model_edge(input logic r, input logic [7:0] s, input logic [7:0] c, input logic y);
      logic [7:0] nxt;
      bit hs;
      if (!r) begin
         m_pend = '0;
         m_off  = -1;
      end else begin
         hs  = (m_off >= 0) && y;
         nxt = m_pend;
         for (int i = 0; i < 8; i++) begin
            if (c[i] || (hs && i == m_off)) nxt[i] = 1'b0;
            if (s[i]) nxt[i] = 1'b1;
         end
         if (m_off < 0)  m_off = pick(m_pend, 1'b0);
         else if (hs)    m_off = pick(nxt, 1'b0);
         m_pend = nxt;
      end
   endtask

   int ord[$];
   int exp_ord[$];

   initial begin
      rst_n = 1'b0; set_in = '0; clr_in = '0; out_rdy = 1'b0;
      rst_h = 1'b0; set_h = '0; clr_h = '0; rdy_h = 1'b0;

      // reset with set_in asserted, then release
      repeat (3) tbl.push_back(mk(0, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 8'h00));
      repeat (2) tbl.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00));
      // burst drain of 2C with consumer ready
      tbl.push_back(mk(1, 8'h2C, 8'h00, 1, 8'h2C, 0, 0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h2C, 1, 2, 8'h04));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h28, 1, 3, 8'h08));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h20, 1, 5, 8'h20));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00));
      // clear of a non-offered bit while stalled
      tbl.push_back(mk(1, 8'h2C, 8'h00, 0, 8'h2C, 0, 0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 8'h00, 0, 8'h2C, 1, 2, 8'h04));
      tbl.push_back(mk(1, 8'h00, 8'h08, 0, 8'h24, 1, 2, 8'h04));
      tbl.push_back(mk(1, 8'h00, 8'h00, 0, 8'h24, 1, 2, 8'h04));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h20, 1, 5, 8'h20));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00));
      // clearing the offered bit does not withdraw the offer
      tbl.push_back(mk(1, 8'h10, 8'h00, 0, 8'h10, 0, 0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 8'h10, 0, 8'h00, 1, 4, 8'h10));
      tbl.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 1, 4, 8'h10));
      tbl.push_back(mk(1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00));

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].rst_n, tbl[k].set, tbl[k].clr, tbl[k].rdy);
         chk($sformatf("tbl%0d pending", k), 32'(pending),    32'(tbl[k].e_pend));
         chk($sformatf("tbl%0d vld", k),     32'(out_vld),    32'(tbl[k].e_vld));
         chk($sformatf("tbl%0d idx", k),     32'(out_idx),    32'(tbl[k].e_idx));
         chk($sformatf("tbl%0d onehot", k),  32'(out_onehot), 32'(tbl[k].e_oh));
      end

      // backpressure: 10 stalled cycles with a new low bit arriving mid-stall
      drive(0, 8'h00, 8'h00, 0);
      drive(1, 8'h2C, 8'h00, 0);
      drive(1, 8'h00, 8'h00, 0);
      for (int i = 0; i < 10; i++) begin
         drive(1, (i == 4) ? 8'h01 : 8'h00, 8'h00, 0);
         chk($sformatf("stall%0d idx", i), 32'(out_idx), 32'd2);
         chk($sformatf("stall%0d oh", i),  32'(out_onehot), 32'h04);
         chk($sformatf("stall%0d vld", i), 32'(out_vld), 32'd1);
      end
      chk("stall pending", 32'(pending), 32'h2D);
      ord.delete();
      out_rdy = 1'b1;
      for (int i = 0; i < 12 && out_vld; i++) begin
         ord.push_back(int'(out_idx));
         step();
      end
      exp_ord = '{2, 0, 3, 5};
      chk("stall order len", 32'(ord.size()), 32'(exp_ord.size()));
      for (int i = 0; i < exp_ord.size() && i < ord.size(); i++)
         chk($sformatf("stall order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));

      // re-arm on service: bit 3 set in the same cycle it is accepted
      drive(0, 8'h00, 8'h00, 0);
      drive(1, 8'h2C, 8'h00, 1);
      drive(1, 8'h00, 8'h00, 1);
      chk("rearm first idx", 32'(out_idx), 32'd2);
      drive(1, 8'h00, 8'h00, 1);
      chk("rearm idx3", 32'(out_idx), 32'd3);
      drive(1, 8'h08, 8'h00, 1);
      chk("rearm pending", 32'(pending), 32'h28);
      chk("rearm reoffer idx", 32'(out_idx), 32'd3);
      drive(1, 8'h00, 8'h00, 1);
      chk("rearm idx5", 32'(out_idx), 32'd5);
      chk("rearm pending2", 32'(pending), 32'h20);
      drive(1, 8'h00, 8'h00, 1);
      chk("rearm done vld", 32'(out_vld), 32'd0);

      // highest-wins instance: order and reset mid-offer
      rst_h = 1'b0; step();
      rst_h = 1'b1; set_h = 8'h2C; rdy_h = 1'b1; step();
      set_h = 8'h00;
      ord.delete();
      for (int i = 0; i < 12; i++) begin
         step();
         if (!vld_h) break;
         ord.push_back(int'(idx_h));
      end
      exp_ord = '{5, 3, 2};
      chk("hi order len", 32'(ord.size()), 32'(exp_ord.size()));
      for (int i = 0; i < exp_ord.size() && i < ord.size(); i++)
         chk($sformatf("hi order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
      set_h = 8'h2C; rdy_h = 1'b0; step();
      set_h = 8'h00; step();
      chk("hi offer vld", 32'(vld_h), 32'd1);
      chk("hi offer oh", 32'(oh_h), 32'h20);
      rst_h = 1'b0; rdy_h = 1'b1; step();
      chk("hi rst vld", 32'(vld_h), 32'd0);
      chk("hi rst pending", 32'(pend_h), 32'h00);
      chk("hi rst idx", 32'(idx_h), 32'd0);
      chk("hi rst oh", 32'(oh_h), 32'h00);
      rst_h = 1'b1;

      // randomized run against the reference model
      m_pend = '0; m_off = -1;
      for (int c = 0; c < 2000; c++) begin
         logic       r, y;
         logic [7:0] s, cl;
         r  = (c == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
         s  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         cl = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
         y  = ($urandom_range(0, 2) != 0);
         model_edge(r, s, cl, y);
         drive(r, s, cl, y);
         chk($sformatf("rnd%0d pending", c), 32'(pending), 32'(m_pend));
         chk($sformatf("rnd%0d vld", c), 32'(out_vld), (m_off >= 0) ? 32'd1 : 32'd0);
         chk($sformatf("rnd%0d idx", c), 32'(out_idx), (m_off >= 0) ? 32'(m_off) : 32'd0);
         chk($sformatf("rnd%0d onehot", c), 32'(out_onehot), (m_off >= 0) ? (32'd1 << m_off) : 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
